// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified instruction/data memory port arbiter:
// FSM state encoding and default bus widths.
package mem_arb_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } arb_state_t;

endpackage

// File: rtl/flopenr.sv
// Enabled datapath register with asynchronous active-low clear.
module flopenr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/mem_arbiter_pick.sv
// Combinational winner select: data has priority unless fetch is starved.
module arb_pick (
    input  logic i_ireq,
    input  logic i_dreq,
    input  logic i_starved,
    output logic o_grant_i,
    output logic o_grant_d
);

    logic w_grant_d;

    assign w_grant_d = i_dreq & ~(i_ireq & i_starved);
    assign o_grant_d = w_grant_d;
    assign o_grant_i = i_ireq & ~w_grant_d;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory req/ack port between instruction fetch and data access,
// returning registered read data with a one-cycle ready pulse to the winner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ireq,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] irdata,
    output logic          iready,
    input  logic          dreq,
    input  logic          dwe,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dwdata,
    output logic [DW-1:0] drdata,
    output logic          dready,
    output logic          mreq,
    output logic          mwe,
    output logic [AW-1:0] maddr,
    output logic [DW-1:0] mwdata,
    input  logic [DW-1:0] mrdata,
    input  logic          mack
);

    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_t    r_state;
    logic [CW-1:0] r_starve_cnt;
    logic          r_mreq;
    logic          r_mwe;
    logic          r_iready;
    logic          r_dready;

    logic w_starved;
    logic w_grant_i;
    logic w_grant_d;
    logic w_grant;
    logic w_cap_i;
    logic w_cap_d;

    assign w_starved = (r_starve_cnt == LIMIT);

    arb_pick u_pick (
        .i_ireq    (ireq),
        .i_dreq    (dreq),
        .i_starved (w_starved),
        .o_grant_i (w_grant_i),
        .o_grant_d (w_grant_d)
    );

    assign w_grant = (r_state == IDLE) & (w_grant_i | w_grant_d);
    assign w_cap_i = (r_state == BUSY_I) & mack;
    // Writes never touch drdata, so the load register only opens for reads.
    assign w_cap_d = (r_state == BUSY_D) & mack & ~r_mwe;

    flopenr #(.W(AW)) u_maddr (
        .clk   (clk),
        .rst_n (reset),
        .i_en  (w_grant),
        .i_d   (w_grant_d ? daddr : iaddr),
        .o_q   (maddr)
    );

    flopenr #(.W(DW)) u_mwdata (
        .clk   (clk),
        .rst_n (reset),
        .i_en  (w_grant),
        .i_d   (w_grant_d ? dwdata : '0),
        .o_q   (mwdata)
    );

    flopenr #(.W(DW)) u_irdata (
        .clk   (clk),
        .rst_n (reset),
        .i_en  (w_cap_i),
        .i_d   (mrdata),
        .o_q   (irdata)
    );

    flopenr #(.W(DW)) u_drdata (
        .clk   (clk),
        .rst_n (reset),
        .i_en  (w_cap_d),
        .i_d   (mrdata),
        .o_q   (drdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_mreq       <= 1'b0;
            r_mwe        <= 1'b0;
            r_iready     <= 1'b0;
            r_dready     <= 1'b0;
        end else begin
            r_iready <= 1'b0;
            r_dready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state <= BUSY_D;
                        r_mreq  <= 1'b1;
                        r_mwe   <= dwe;
                        // Count only data grants that actually bypass a waiting fetch.
                        if (!ireq) begin
                            r_starve_cnt <= '0;
                        end else if (!w_starved) begin
                            r_starve_cnt <= r_starve_cnt + CW'(1);
                        end
                    end else if (w_grant_i) begin
                        r_state      <= BUSY_I;
                        r_mreq       <= 1'b1;
                        r_mwe        <= 1'b0;
                        r_starve_cnt <= '0;
                    end
                end
                BUSY_I: begin
                    if (mack) begin
                        r_state  <= RESP_I;
                        r_mreq   <= 1'b0;
                        r_mwe    <= 1'b0;
                        r_iready <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mack) begin
                        r_state  <= RESP_D;
                        r_mreq   <= 1'b0;
                        r_mwe    <= 1'b0;
                        r_dready <= 1'b1;
                    end
                end
                RESP_I, RESP_D: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_mreq  <= 1'b0;
                    r_mwe   <= 1'b0;
                end
            endcase
        end
    end

    assign mreq   = r_mreq;
    assign mwe    = r_mwe;
    assign iready = r_iready;
    assign dready = r_dready;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sequences a single unified memory port shared by the instruction-fetch stage and the data-memory stage of the pipelined core. It arbitrates between the two requesters and drives a req/ack memory handshake. It returns registered read data plus a one-cycle ready pulse to the winner. Data accesses win by default; a starvation limit guarantees forward progress for instruction fetch.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_LIMIT, 4, max consecutive data grants made while ireq is pending before fetch is forced; legal range 1..15
CW, 4, starvation counter width; must hold STARVE_LIMIT

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets)
ireq  in  1  instruction read request; held until iready
iaddr  in  AW  fetch address; stable while ireq held
irdata  out  DW  registered fetch data; valid when iready=1, held until the next fetch completes
iready  out  1  one-cycle completion pulse to fetch
dreq  in  1  data request; held until dready
dwe  in  1  1=write, 0=read; stable while dreq held
daddr  in  AW  data address
dwdata  in  DW  write data
drdata  out  DW  registered load data; valid when dready=1, held until the next data read completes
dready  out  1  one-cycle completion pulse to data stage
mreq  out  1  memory request; held until mack
mwe  out  1  memory write enable
maddr  out  AW  memory address
mwdata  out  DW  memory write data
mrdata  in  DW  memory read data; valid when mack=1
mack  in  1  one-cycle memory acknowledge; any latency >=0 cycles after mreq rises

Behaviour:
- Reset (async, reset=0): state=IDLE, starve_cnt=0; mreq, mwe, iready, dready=0; maddr, mwdata, irdata, drdata=0. Takes effect immediately, including mid-transaction. An in-flight memory access is abandoned and no ready is pulsed.
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE: sample ireq/dreq and select a winner.
  - Data wins if dreq and not (ireq and starve_cnt==STARVE_LIMIT). Otherwise fetch wins if ireq. No request keeps IDLE.
  - On a grant, latch the winner's addr, wdata and we into maddr/mwdata/mwe. Next state BUSY_x. mreq=1 from the next cycle; mwe=0 for a fetch.
- BUSY_x: mreq, mwe, maddr and mwdata are held stable.
  - If mack, capture mrdata into irdata or drdata (not for data writes) and go to RESP_x. mreq drops in the same edge.
  - If mack is absent, stay in BUSY_x indefinitely; there is no timeout.
- RESP_x: pulse iready or dready for exactly one cycle, then go to IDLE.
  - The requester must drop req or present a new transaction by the next edge, so IDLE never re-grants a completed request.
- Latency: request sampled in IDLE at cycle t; mreq high from t+1; mack at cycle m; ready at m+1. Best case with zero-wait mack at t+1: ready at t+2, and a back-to-back grant is sampled at t+3.
- Starvation counter:
  - On a data grant with ireq=1: starve_cnt += 1, saturating at STARVE_LIMIT.
  - On a data grant with ireq=0, or on any fetch grant: starve_cnt=0.
  - The counter changes only at grant edges.
- Simultaneous ireq and dreq with starve_cnt<STARVE_LIMIT: data wins. With starve_cnt==STARVE_LIMIT: fetch wins and the counter clears.
- Spurious mack in IDLE or RESP_x is ignored. irdata/drdata are unchanged when the other requester or a data write completes.
- Requests dropped before ready is a protocol violation; behaviour is unspecified and need not be handled.

Decomposition:
- Shared package mem_arb_pkg: state encoding localparams (IDLE=3'd0, BUSY_I=3'd1, BUSY_D=3'd2, RESP_I=3'd3, RESP_D=3'd4) and default widths.
- Sub-module arb_pick: combinational winner select from ireq, dreq and the starvation flag (starve_cnt==STARVE_LIMIT).
- Datapath registers use existing flopr/flopenr-style primitives rewritten for the active-low async reset.

Test Plan:
- Reset mid-BUSY_D (reset=0 while mreq=1) -> mreq=0 in the same cycle; after release, state is IDLE, no dready, irdata=drdata=0.
- Fetch only: ireq=1, iaddr=0x00000040, mack two cycles after mreq with mrdata=0x8C080004 -> maddr=0x40, mwe=0, iready one cycle after mack, irdata=0x8C080004.
- Data write: dreq=1, dwe=1, daddr=0x100, dwdata=0xDEADBEEF, zero-wait mack -> mwe=1, mwdata=0xDEADBEEF, dready pulse; drdata unchanged.
- Contention: ireq and dreq held high continuously, STARVE_LIMIT=4, zero-wait mack -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each I.
- Stalled memory: mack withheld 20 cycles in BUSY_I while dreq rises -> mreq and maddr stable for all 20 cycles; fetch completes first, then data is granted.
- Spurious mack pulses in IDLE -> no iready/dready and no state change.
